bbq_op_scheduler: RTL

Request-conditioning stage directly upstream of the `bbq` priority queue. Accepts enqueue/dequeue-min requests from a producer over a valid/ready handshake, buffers them in a small FIFO, and issues them to `bbq` one per cycle only while `bbq` reports ready. It keeps a shadow occupancy count so that no dequeue is sent to an empty queue and no enqueue is sent to a full queue. Dropped requests are counted, never forwarded.

---
 rtl/bbq_pkg.sv | 31 +++
 rtl/bbq_op_scheduler_if.sv | 25 ++
 rtl/bbq_op_fifo.sv | 77 +++++++
 rtl/bbq_op_scheduler.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bbq_pkg.sv
// Shared types and width helpers for the bbq priority queue
// and its request scheduler.
package bbq_pkg;

    typedef enum logic [1:0] {
        HEAP_OP_ENQUE     = 2'd0,
        HEAP_OP_DEQUE_MIN = 2'd1,
        HEAP_OP_DEQUE_MAX = 2'd2
    } heap_op_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } sched_state_t;

    localparam int OP_W = $bits(heap_op_t);

    function automatic int prio_w(input int bw, input int nl);
        return $clog2(bw ** nl);
    endfunction

    function automatic int cnt_w(input int max_entries);
        return $clog2(max_entries);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bbq_op_scheduler_if.sv
// One heap request channel: valid/ready plus op, data, priority.
// The scheduler is slave on its input side and master toward bbq.
interface bbq_op_scheduler_if #(
    parameter int DW = 17,
    parameter int PW = 15
);
    import bbq_pkg::*;

    logic          valid;
    logic          ready;
    heap_op_t      op_type;
    logic [DW-1:0] he_data;
    logic [PW-1:0] he_priority;

    modport master (
        output valid, op_type, he_data, he_priority,
        input  ready
    );

    modport slave (
        input  valid, op_type, he_data, he_priority,
        output ready
    );

endinterface

// File: rtl/bbq_op_fifo.sv
// Register-based synchronous request FIFO with push, pop, level
// and clear. Push while full and pop while empty are ignored.
module bbq_op_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level
);

    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          push_ok, pop_ok;

    assign push_ok = push && (lvl_q != FULL);
    assign pop_ok  = pop && (lvl_q != '0);
    assign rdata   = mem_q[rd_q];
    assign level   = lvl_q;

    // Next pointers, level and storage contents.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            lvl_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = wdata;
                wr_d        = wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_d = rd_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                lvl_d = lvl_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                lvl_d = lvl_q - 1'b1;
            end
        end
    end

    // Pointer and level registers; buffered entries die with reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    // Storage needs no reset: the level gates what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bbq_op_scheduler.sv
// Conditions enqueue/dequeue-min requests ahead of bbq: buffers,
// gates on bbq readiness and drops requests bbq cannot take.
module bbq_op_scheduler
    import bbq_pkg::*;
#(
    parameter int HEAP_BITMAP_WIDTH    = 32,
    parameter int NB_LEVELS            = 3,
    parameter int HEAP_ENTRY_DWIDTH    = 17,
    parameter int HEAP_MAX_NUM_ENTRIES = (1 << 17) - 1,
    parameter int FIFO_DEPTH           = 8,
    localparam int PRIO_W = prio_w(HEAP_BITMAP_WIDTH, NB_LEVELS),
    localparam int CNT_W  = cnt_w(HEAP_MAX_NUM_ENTRIES),
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    bbq_op_scheduler_if.slave  in_if,
    bbq_op_scheduler_if.master out_if,
    output logic [CNT_W-1:0]   occupancy,
    output logic [LVL_W-1:0]   fifo_level,
    output logic [31:0]        drop_empty_cnt,
    output logic [31:0]        drop_full_cnt,
    output logic [31:0]        drop_illegal_cnt
);

    localparam int EW = OP_W + HEAP_ENTRY_DWIDTH + PRIO_W;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAXC = CNT_W'(HEAP_MAX_NUM_ENTRIES);

    sched_state_t state_q, state_d;
    logic in_ready_q, in_ready_d;
    logic out_valid_q, out_valid_d;
    heap_op_t out_op_q, out_op_d;
    logic [HEAP_ENTRY_DWIDTH-1:0] out_data_q, out_data_d;
    logic [PRIO_W-1:0] out_prio_q, out_prio_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [31:0] de_q, de_d, df_q, df_d, di_q, di_d;

    logic push, pop;
    logic [EW-1:0] wdata, rdata;
    logic [LVL_W-1:0] lvl_nxt;
    heap_op_t head_op;
    logic [HEAP_ENTRY_DWIDTH-1:0] head_data;
    logic [PRIO_W-1:0] head_prio;
    logic is_enq, is_deq, occ_full, occ_zero;

    assign push      = in_if.valid && in_ready_q;
    assign wdata     = {in_if.op_type, in_if.he_data, in_if.he_priority};
    assign head_op   = heap_op_t'(rdata[EW-1 -: OP_W]);
    assign head_data = rdata[PRIO_W +: HEAP_ENTRY_DWIDTH];
    assign head_prio = rdata[PRIO_W-1:0];
    assign is_enq    = (head_op == HEAP_OP_ENQUE);
    assign is_deq    = (head_op == HEAP_OP_DEQUE_MIN);
    assign occ_full  = (occ_q == MAXC);
    assign occ_zero  = (occ_q == '0);

    bbq_op_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .level (fifo_level)
    );

    // Next state, head classification, issue and drop counting.
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        out_op_d    = out_op_q;
        out_data_d  = out_data_q;
        out_prio_d  = out_prio_q;
        occ_d       = occ_q;
        de_d        = de_q;
        df_d        = df_q;
        di_d        = di_q;
        pop         = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (out_if.ready) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (out_if.ready && fifo_level != '0) begin
                    pop = 1'b1;
                    unique case (1'b1)
                        is_enq && !occ_full: begin
                            out_valid_d = 1'b1;
                            occ_d       = occ_q + 1'b1;
                        end
                        is_enq && occ_full: df_d = sat_inc(df_q);
                        is_deq && !occ_zero: begin
                            out_valid_d = 1'b1;
                            occ_d       = occ_q - 1'b1;
                        end
                        is_deq && occ_zero: de_d = sat_inc(de_q);
                        default: di_d = sat_inc(di_q);
                    endcase
                    if (out_valid_d) begin
                        out_op_d   = head_op;
                        out_data_d = head_data;
                        out_prio_d = head_prio;
                    end
                end
            end
            ST_FLUSH: begin
                if (fifo_level != '0) pop = 1'b1;
                else if (!flush) state_d = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase
        lvl_nxt = fifo_level;
        if (push && !pop) lvl_nxt = fifo_level + 1'b1;
        if (pop && !push) lvl_nxt = fifo_level - 1'b1;
        in_ready_d = (state_d != ST_FLUSH) && (lvl_nxt != FULL);
    end

    // FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_op_q    <= HEAP_OP_ENQUE;
            out_data_q  <= '0;
            out_prio_q  <= '0;
            occ_q       <= '0;
            de_q        <= '0;
            df_q        <= '0;
            di_q        <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_data_q  <= out_data_d;
            out_prio_q  <= out_prio_d;
            occ_q       <= occ_d;
            de_q        <= de_d;
            df_q        <= df_d;
            di_q        <= di_d;
        end
    end

    assign in_if.ready        = in_ready_q;
    assign out_if.valid       = out_valid_q;
    assign out_if.op_type     = out_op_q;
    assign out_if.he_data     = out_data_q;
    assign out_if.he_priority = out_prio_q;
    assign occupancy          = occ_q;
    assign drop_empty_cnt     = de_q;
    assign drop_full_cnt      = df_q;
    assign drop_illegal_cnt   = di_q;

endmodule
